// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, state encoding and digit validity helper for the BCD serial adder
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [4:0] BCD_CORR = 5'd6;
  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;
  function automatic logic is_bcd_digit(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: single-digit BCD add with decimal correction, invalid digits handled by the same rule
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] raw;
  // binary sum, then add 6 and wrap to a digit whenever the sum leaves the decimal range
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    co  = raw > {1'b0, BCD_MAX};
    s   = co ? 4'(raw + BCD_CORR) : raw[3:0];
  end
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: accepts packed BCD operands and adds them one digit per cycle, LSD first
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] a_bcd,
  input  logic [DIGIT_W*DIGITS-1:0] b_bcd,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*DIGITS-1:0] sum_bcd,
  output logic                    cout,
  output logic                    err
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int W = DIGIT_W * DIGITS;
  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic           carry_q, carry_d, cout_q, cout_d, err_q, err_d;
  logic [3:0]     dig_s;
  logic           dig_co, bad;
  bcd_digit_add u_add (
    .a  (a_q[idx_q*DIGIT_W +: DIGIT_W]),
    .b  (b_q[idx_q*DIGIT_W +: DIGIT_W]),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == HOLD;
  assign sum_bcd   = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  // flag any operand digit outside 0..9 at acceptance time
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | ~is_bcd_digit(a_bcd[i*DIGIT_W +: DIGIT_W]) | ~is_bcd_digit(b_bcd[i*DIGIT_W +: DIGIT_W]);
  end
  // sequencer: accept operands, walk the digits through the adder, hold the result until taken
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a_bcd;
        b_d     = b_bcd;
        carry_d = cin;
        sum_d   = '0;
        idx_d   = '0;
        err_d   = bad;
        state_d = ADD;
      end
      ADD: begin
        sum_d[idx_q*DIGIT_W +: DIGIT_W] = dig_s;
        carry_d = dig_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(DIGITS - 1)) begin
          cout_d  = dig_co;
          state_d = HOLD;
        end
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed vectors with hand-computed BCD sums
module tb_bcd_serial_adder;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, cout, err;
  logic [4*D-1:0] a_bcd = '0, b_bcd = '0, sum_bcd;
  int n_cmp = 0, n_bad = 0;
  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_bcd(a_bcd), .b_bcd(b_bcd), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum_bcd(sum_bcd), .cout(cout), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic c,
                    input logic [15:0] es, input logic ec, input logic ee,
                    input int hold, input bit noise);
    int cyc;
    chk("in_ready_idle", 32'(in_ready), 1);
    a_bcd = a;
    b_bcd = b;
    cin = c;
    in_valid = 1'b1;
    tick();
    if (noise) begin
      a_bcd = ~a;
      b_bcd = 16'h4321;
      cin = ~c;
    end else in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      chk("in_ready_add", 32'(in_ready), 0);
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), D);
    chk("sum", 32'(sum_bcd), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    chk("err", 32'(err), 32'(ee));
    chk("in_ready_hold", 32'(in_ready), 0);
    repeat (hold) begin
      tick();
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_sum", 32'(sum_bcd), 32'(es));
      chk("hold_cout", 32'(cout), 32'(ec));
      chk("hold_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_valid", 32'(out_valid), 0);
    chk("handoff_ready", 32'(in_ready), 1);
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum_bcd), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("early_ready_valid", 32'(out_valid), 0);
    chk("early_ready_in", 32'(in_ready), 1);
    op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 0, 0);
    op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0);
    op(16'h0005, 16'h0009, 1'b1, 16'h0015, 1'b0, 1'b0, 0, 0);
    op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 2, 1);
    op(16'h0808, 16'h0909, 1'b0, 16'h1717, 1'b0, 1'b0, 10, 0);
    op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1, 0, 0);
    a_bcd = 16'h1234;
    b_bcd = 16'h5678;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_sum", 32'(sum_bcd), 0);
    chk("midrst_cout", 32'(cout), 0);
    chk("midrst_err", 32'(err), 0);
    repeat (D + 2) begin
      tick();
      chk("midrst_idle", 32'(out_valid), 0);
    end
    op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
